// File: rtl/spi_master.sv
// spi_master: single-byte SPI bus master, all four SPI modes, MSB first, one chip select
//
// Ports:
//   clk            system clock, all logic on the rising edge
//   rst            asynchronous reset, active-low (0 = reset)
//   start          one-cycle transfer request, accepted only in IDLE
//   miso           serial data from the slave
//   data_to_send   byte to transmit, latched when start is accepted
//   mode           {CPOL, CPHA}, latched when start is accepted
//   mosi           serial data to the slave, MSB first
//   sclk           SPI clock, idles at CPOL
//   cs_n           chip select, active-low, low only while transferring
//   done           one-cycle pulse when the transfer finishes
//   data_received  last received byte, held until the next transfer completes
module spi_master #(
    parameter int DIVIDER = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       miso,
    input  logic [7:0] data_to_send,
    input  logic [1:0] mode,
    output logic       mosi,
    output logic       sclk,
    output logic       cs_n,
    output logic       done,
    output logic [7:0] data_received
);
    localparam int CW = (DIVIDER > 2) ? $clog2(DIVIDER) : 1;
    localparam logic [1:0] IDLE = 2'd0, TRANSFER = 2'd1, DONE = 2'd2;
    localparam logic [CW-1:0] DIV_LAST = CW'(DIVIDER - 1);
    logic [1:0] state, state_nx;
    logic [CW-1:0] div_cnt;
    logic [4:0] edge_cnt;
    logic [7:0] tx, rx;
    logic [1:0] mode_q;
    logic sample_edge, shift_edge;
    logic term, lead, do_sample, do_shift;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else state <= state_nx;
    end
    always_comb begin
        state_nx = IDLE;
        case (state)
            IDLE:     state_nx = start ? TRANSFER : IDLE;
            TRANSFER: state_nx = (edge_cnt == 5'd16) ? DONE : TRANSFER;
            default:  state_nx = IDLE;
        endcase
    end
    always_comb begin
        cs_n = (state != TRANSFER);
        done = (state == DONE);
    end
    // edge_cnt holds the number of edges already produced, so the upcoming
    // edge is odd (leading) exactly when edge_cnt is even.
    always_comb begin
        term      = (state == TRANSFER) && (div_cnt == DIV_LAST) && (edge_cnt != 5'd16);
        lead      = ~edge_cnt[0];
        do_sample = term && (mode_q[0] ? ~lead : lead);
        // In CPHA=0 the final trailing edge must not shift, or mosi would lose tx[0].
        do_shift  = term && (mode_q[0] ? lead : (~lead && edge_cnt != 5'd15));
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sclk          <= 1'b0;
            mosi          <= 1'b0;
            data_received <= 8'h00;
            div_cnt       <= '0;
            edge_cnt      <= '0;
            tx            <= 8'h00;
            rx            <= 8'h00;
            mode_q        <= 2'b00;
            sample_edge   <= 1'b0;
            shift_edge    <= 1'b0;
        end else begin
            sample_edge <= do_sample;
            shift_edge  <= do_shift;
            if (state == IDLE) begin
                sclk <= mode[1];
                if (start) begin
                    tx       <= data_to_send;
                    mode_q   <= mode;
                    div_cnt  <= '0;
                    edge_cnt <= '0;
                    if (!mode[0]) mosi <= data_to_send[7];
                end
            end
            if (state == TRANSFER) begin
                div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + CW'(1);
                if (term) begin
                    sclk     <= ~sclk;
                    edge_cnt <= edge_cnt + 5'd1;
                end
                if (do_sample) rx <= {rx[6:0], miso};
                // CPHA=0 already drove tx[7] at entry, so its shifts present the next bit.
                if (do_shift) begin
                    mosi <= mode_q[0] ? tx[7] : tx[6];
                    tx   <= {tx[6:0], 1'b0};
                end
            end
            if (state == DONE) data_received <= rx;
        end
    end
endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: randomized and directed checks of spi_master against a cycle-indexed transfer model
module tb_spi_master;
    localparam int D = 4;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0, miso = 1'b0;
    logic [7:0] data_to_send = 8'h00;
    logic [1:0] mode = 2'b00;
    logic mosi, sclk, cs_n, done;
    logic [7:0] data_received;
    spi_master #(.DIVIDER(D)) dut (
        .clk(clk), .rst(rst), .start(start), .miso(miso),
        .data_to_send(data_to_send), .mode(mode),
        .mosi(mosi), .sclk(sclk), .cs_n(cs_n), .done(done),
        .data_received(data_received)
    );
    always #5 clk = ~clk;
    int total = 0, bad = 0;
    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask
    // Slave: shifts s_byte out MSB first on its shift edge, captures mosi on its sample edge.
    logic [7:0] s_byte = 8'h00, cap = 8'h00;
    logic cpol_s = 1'b0, cpha_s = 1'b0, psclk = 1'b0, pcs = 1'b1;
    int sh = 0, cyc = -1, lat_done = -1, dcnt = 0, rises = 0;
    always @(negedge clk) begin
        int idx;
        if (cs_n) begin
            sh = 0;
            miso = s_byte[7];
        end else if (!pcs && sclk !== psclk) begin
            if (sclk) rises++;
            if ((sclk != cpol_s) == cpha_s) begin
                sh++;
                idx = cpha_s ? 8 - sh : 7 - sh;
                if (idx >= 0 && idx <= 7) miso = s_byte[idx];
            end else cap = {cap[6:0], mosi};
        end
        if (pcs && !cs_n) cyc = 0;
        else if (cyc >= 0) cyc++;
        if (done) begin
            dcnt++;
            lat_done = cyc;
        end
        psclk = sclk;
        pcs = cs_n;
    end
    // Model: c counts cycles since TRANSFER entry (-1 idle, 16*D+1 is the done cycle).
    int c = -1;
    logic [7:0] m_tx = 8'h00, m_s = 8'h00, m_dr = 8'h00;
    logic [1:0] m_mode = 2'b00;
    logic ms = 1'b0, mm = 1'b0;
    always @(negedge clk) begin
        int k;
        logic xf, ld, ed, e_sclk, e_samp, e_shift, e_mosi, e_done;
        if (!rst) begin
            c = -1; ms = 1'b0; mm = 1'b0; m_dr = 8'h00;
        end
        xf = (c >= 0) && (c <= 16 * D);
        k = xf ? c / D : 0;
        ld = (k % 2) == 1;
        ed = xf && c > 0 && (c % D) == 0;
        e_done = (c == 16 * D + 1);
        e_sclk = xf ? (m_mode[1] ^ ld) : ms;
        e_samp = ed && (m_mode[0] ? !ld : ld);
        e_shift = ed && (m_mode[0] ? ld : (!ld && k != 16));
        e_mosi = !xf ? mm : !m_mode[0] ? m_tx[7 - ((k / 2 > 7) ? 7 : k / 2)] :
                 (k == 0) ? mm : m_tx[7 - (k - 1) / 2];
        chk("cs_n", 8'(cs_n), 8'(!xf));
        chk("done", 8'(done), 8'(e_done));
        chk("sclk", 8'(sclk), 8'(e_sclk));
        chk("mosi", 8'(mosi), 8'(e_mosi));
        chk("sample_edge", 8'(dut.sample_edge), 8'(e_samp));
        chk("shift_edge", 8'(dut.shift_edge), 8'(e_shift));
        chk("data_received", data_received, m_dr);
        if (rst) begin
            if (c == -1) begin
                ms = mode[1];
                if (start) begin
                    c = 0; m_tx = data_to_send; m_mode = mode; m_s = s_byte;
                end
            end else begin
                if (xf) mm = e_mosi;
                ms = m_mode[1];
                if (e_done) begin
                    c = -1; m_dr = m_s;
                end else c++;
            end
        end
    end
    task automatic xfer(input logic [7:0] tx, input logic [1:0] m, input logic [7:0] s,
                        input int gap, input bit mid);
        bit got = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        @(posedge clk); #1;
        data_to_send = tx; mode = m; s_byte = s; cpol_s = m[1]; cpha_s = m[0];
        cap = 8'h00; dcnt = 0; rises = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int n = 0; n < 200 && !got; n++) begin
            if (mid && n == 20) begin
                start = 1'b1; data_to_send = ~tx; mode = ~m;
            end else start = 1'b0;
            @(posedge clk); #1;
            if (done) got = 1'b1;
        end
        start = 1'b0;
        chk("done_seen", 8'(got), 8'd1);
    endtask
    initial begin
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        // Mode 0 reference transfer and timing
        xfer(8'h3C, 2'd0, 8'hA5, 2, 1'b0);
        @(posedge clk); #1;
        chk("t1_rx", data_received, 8'hA5);
        chk("t1_mosi_bits", cap, 8'h3C);
        chk("t1_done_width", 8'(dcnt), 8'd1);
        chk("t2_done_latency", 8'(lat_done), 8'd65);
        chk("t2_rises", 8'(rises), 8'd8);
        // Modes 1..3
        for (int m = 1; m < 4; m++) begin
            xfer(8'h81, 2'(m), 8'h5A, 3, 1'b0);
            @(posedge clk); #1;
            chk("t3_rx", data_received, 8'h5A);
            chk("t3_mosi_bits", cap, 8'h81);
            chk("t3_rises", 8'(rises), 8'd8);
        end
        // Start and input changes mid-transfer are ignored
        xfer(8'h96, 2'd0, 8'h3C, 1, 1'b1);
        @(posedge clk); #1;
        chk("t4_rx", data_received, 8'h3C);
        chk("t4_mosi_bits", cap, 8'h96);
        chk("t4_single_done", 8'(dcnt), 8'd1);
        // Reset mid-transfer: previous result is 0x00, so no partial 0xFF bits may appear
        xfer(8'hFF, 2'd0, 8'h00, 1, 1'b0);
        @(posedge clk); #1;
        chk("t5_pre_rx", data_received, 8'h00);
        data_to_send = 8'h55; mode = 2'd0; s_byte = 8'hFF; cpol_s = 1'b0; cpha_s = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (30) begin @(posedge clk); #1; end
        rst = 1'b0;
        #1;
        chk("t5_rst_cs_n", 8'(cs_n), 8'd1);
        chk("t5_rst_sclk", 8'(sclk), 8'd0);
        chk("t5_rst_done", 8'(done), 8'd0);
        chk("t5_rst_rx", data_received, 8'h00);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        xfer(8'h00, 2'd2, 8'hC3, 1, 1'b0);
        @(posedge clk); #1;
        chk("t5_post_rx", data_received, 8'hC3);
        // Back-to-back: second start in the cycle after done
        xfer(8'hFF, 2'd0, 8'h00, 0, 1'b0);
        xfer(8'h00, 2'd0, 8'hFF, 0, 1'b0);
        @(posedge clk); #1;
        chk("t6_rx", data_received, 8'hFF);
        chk("t6_mosi_bits", cap, 8'h00);
        // Randomized transfers
        for (int i = 0; i < 24; i++) begin
            logic [7:0] t, s;
            logic [1:0] m;
            t = 8'($urandom); s = 8'($urandom); m = 2'($urandom_range(0, 3));
            xfer(t, m, s, $urandom_range(0, 3), $urandom_range(0, 3) == 0);
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clk); #1;
                chk("rnd_rx", data_received, s);
                chk("rnd_mosi_bits", cap, t);
            end
        end
        repeat (4) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
